// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory arbiter slice.
// Word type, arbiter state encoding and a counter width helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } arb_state_t;

  function automatic int cnt_w(input int max_v);
    return (max_v < 2) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/arb_if.sv
// Memory-control bundle between fetch/data ports, arbiter and RAM.
// Modports give each side its own view of the handshake.
interface arb_if
  import cpu_types_pkg::*;
(
  input logic CLK
);

  logic  RST;
  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  ramReady;
  word_t ramload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  logic  ihit;
  logic  dhit;
  word_t iload;
  word_t dload;
  logic  iwait;
  logic  dwait;
  logic  err;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN,
    input  daddr, dstore, ramReady, ramload,
    output ramREN, ramWEN, ramaddr, ramstore,
    output ihit, dhit, iload, dload,
    output iwait, dwait, err
  );

  modport cache (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, dhit, iload, dload,
    input  iwait, dwait, err
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramReady, ramload
  );

  modport tb (
    input  CLK,
    output RST, iREN, iaddr, dREN, dWEN,
    output daddr, dstore, ramReady, ramload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    input  ihit, dhit, iload, dload,
    input  iwait, dwait, err
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Saturating up-counter with clear/enable and a terminal flag.
// Shared by the RAM timeout and the fetch starvation guard.
module arb_timeout_ctr #(
  parameter int MAX = 255,
  parameter int W   = 8
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [W-1:0] LMAX = W'(MAX);

  logic [W-1:0] r_cnt;

  assign o_term = (r_cnt == LMAX);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// IF/MEM arbiter for the single-ported RAM, data port first.
// MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int RAM_TIMEOUT = 255
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
)(
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  input  logic  ramReady,
  input  word_t ramload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  output logic  ihit,
  output logic  dhit,
  output word_t iload,
  output word_t dload,
  output logic  iwait,
  output logic  dwait,
  output logic  err
);

  localparam int TW = cnt_w(RAM_TIMEOUT);

  arb_state_t r_state;
  arb_state_t w_next;
  word_t      r_addr;
  word_t      r_store;
  logic       r_wr;

  logic w_dreq;
  logic w_busy;
  logic w_done;
  logic w_term;
  logic w_idle;
  logic w_guard;
  logic w_to_en;

  assign w_dreq  = dREN | dWEN;
  assign w_idle  = (r_state == IDLE);
  assign w_busy  = !w_idle;
  assign w_done  = w_busy & ramReady & ~RST;
  assign w_to_en = w_busy & ~ramReady;

  arb_timeout_ctr #(
    .MAX (RAM_TIMEOUT),
    .W   (TW)
  ) u_to (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_idle),
    .i_en   (w_to_en),
    .o_term (w_term)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW0 = cnt_w(STARVE_MAX);
  localparam int SW  = (SW0 < 3) ? 3 : SW0;

  logic w_sterm;
  logic w_sinc;
  logic w_sclr;

  assign w_sinc = w_idle & (w_next == DGNT) & iREN;
  assign w_sclr = w_idle & (~iREN | (w_next == IGNT));

  arb_timeout_ctr #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_sclr),
    .i_en   (w_sinc),
    .o_term (w_sterm)
  );

  assign w_guard = w_sterm & iREN;
`else
  assign w_guard = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_dreq && !w_guard) begin
          w_next = DGNT;
        end else if (iREN) begin
          w_next = IGNT;
        end
      end
      IGNT: begin
        ramREN   = 1'b1;
        ramaddr  = r_addr;
        ramstore = r_store;
        ihit     = w_done & iREN;
        iload    = ihit ? ramload : '0;
        if (ramReady || w_term) w_next = IDLE;
      end
      DGNT: begin
        ramREN   = ~r_wr;
        ramWEN   = r_wr;
        ramaddr  = r_addr;
        ramstore = r_store;
        dhit     = w_done & w_dreq;
        dload    = dhit ? ramload : '0;
        if (ramReady || w_term) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign err   = w_busy & ~ramReady & w_term & ~RST;
  assign iwait = iREN & ~ihit;
  assign dwait = w_dreq & ~dhit;

  // Command is captured on the grant edge and held until completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
    end else if (w_idle && w_next == DGNT) begin
      r_addr  <= daddr;
      r_store <= dstore;
      r_wr    <= dWEN;
    end else if (w_idle && w_next == IGNT) begin
      r_addr  <= iaddr;
      r_store <= '0;
      r_wr    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios
// plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 255;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  arb_if bus (.CLK(clk));

  mem_arbiter #(.RAM_TIMEOUT(TO)) dut (
    .CLK      (clk),
    .RST      (bus.RST),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .ramReady (bus.ramReady),
    .ramload  (bus.ramload),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .ihit     (bus.ihit),
    .dhit     (bus.dhit),
    .iload    (bus.iload),
    .dload    (bus.dload),
    .iwait    (bus.iwait),
    .dwait    (bus.dwait),
    .err      (bus.err)
  );

  int total = 0;
  int bad   = 0;

  // Model: who owns the RAM, how long it has waited, what it asked.
  int    m_own;
  int    m_wait;
  int    m_starve;
  word_t m_addr;
  word_t m_store;
  bit    m_wr;

  logic [6:0] e_flags;
  word_t      e_addr;
  word_t      e_store;
  word_t      e_iload;
  word_t      e_dload;

  function automatic logic [6:0] flags();
    return {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit,
            bus.iwait, bus.dwait, bus.err};
  endfunction

  task automatic model_clear();
    m_own = 0; m_wait = 0; m_starve = 0;
    m_addr = '0; m_store = '0; m_wr = 1'b0;
  endtask

  task automatic model_eval();
    bit busy, fin, tmo, dq, ih, dh;
    busy = (m_own != 0);
    dq   = bus.dREN | bus.dWEN;
    fin  = busy && bus.ramReady && !bus.RST;
    tmo  = busy && !bus.ramReady && m_wait == TO && !bus.RST;
    ih   = (m_own == 1) && fin && bus.iREN;
    dh   = (m_own == 2) && fin && dq;
    e_flags = {m_own == 1 || (m_own == 2 && !m_wr),
               m_own == 2 && m_wr, ih, dh,
               bus.iREN && !ih, dq && !dh, tmo};
    e_addr  = busy ? m_addr : '0;
    e_store = busy ? m_store : '0;
    e_iload = ih ? bus.ramload : '0;
    e_dload = dh ? bus.ramload : '0;
  endtask

  task automatic model_adv();
    bit dq, guard;
    dq = bus.dREN | bus.dWEN;
    guard = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard = (m_starve == SM) && bus.iREN;
`endif
    if (bus.RST) begin
      model_clear();
    end else if (m_own == 0) begin
      if (dq && !guard) begin
        m_own = 2; m_wait = 0;
        m_addr = bus.daddr; m_store = bus.dstore;
        m_wr = bus.dWEN;
        m_starve = bus.iREN ? m_starve + 1 : 0;
      end else if (bus.iREN) begin
        m_own = 1; m_wait = 0;
        m_addr = bus.iaddr; m_store = '0; m_wr = 1'b0;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end else if (bus.ramReady || m_wait == TO) begin
      m_own = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic drive(bit ir, word_t ia, bit dr, bit dw,
                       word_t da, word_t ds, bit rr, word_t rl);
    bus.iREN = ir; bus.iaddr = ia;
    bus.dREN = dr; bus.dWEN = dw;
    bus.daddr = da; bus.dstore = ds;
    bus.ramReady = rr; bus.ramload = rl;
  endtask

  task automatic do_reset();
    bus.RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    bus.RST = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.RST = 1'b1;
    drive(1, 32'h10, 1, 0, 32'h20, 32'h5, 1, 32'h1234);
    @(negedge clk);
    #1;
    total++;
    if (flags() !== 7'b0000110) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b", flags(), 7'b0000110);
    end
    total++;
    if ({bus.ramaddr, bus.ramstore} !== 64'd0) begin
      bad++;
      $display("FAIL reset_ram got=%h/%h want=0/0",
               bus.ramaddr, bus.ramstore);
    end
    total++;
    if ({bus.iload, bus.dload} !== 64'd0) begin
      bad++;
      $display("FAIL reset_load got=%h/%h want=0/0",
               bus.iload, bus.dload);
    end
  endtask

  task automatic test_ifetch();
    do_reset();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
      bad++;
      $display("FAIL if_c0 got ren=%b iwait=%b want 0 1",
               bus.ramREN, bus.iwait);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 ||
        bus.ihit !== 1'b0) begin
      bad++;
      $display("FAIL if_c1 got ren=%b addr=%h hit=%b want 1 40 0",
               bus.ramREN, bus.ramaddr, bus.ihit);
    end
    @(negedge clk);
    drive(1, 32'h40, 0, 0, 0, 0, 1, 32'h2408000A);
    #1;
    total++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h2408000A ||
        bus.ramREN !== 1'b1 || bus.iwait !== 1'b0) begin
      bad++;
      $display("FAIL if_c2 got hit=%b load=%h ren=%b wait=%b",
               bus.ihit, bus.iload, bus.ramREN, bus.iwait);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      bad++;
      $display("FAIL if_c3 got ren=%b hit=%b want 0 0",
               bus.ramREN, bus.ihit);
    end
  endtask

  task automatic test_data_first();
    do_reset();
    drive(1, 32'h100, 0, 1, 32'h80, 32'hDEAD, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0111 ||
        bus.ramaddr !== 32'h80 || bus.ramstore !== 32'hDEAD) begin
      bad++;
      $display("FAIL df_c1 got rw=%b%b w=%b%b a=%h s=%h",
               bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait,
               bus.ramaddr, bus.ramstore);
    end
    @(negedge clk);
    bus.ramReady = 1'b1;
    #1;
    total++;
    if (bus.dhit !== 1'b1 || bus.ihit !== 1'b0 ||
        bus.iwait !== 1'b1) begin
      bad++;
      $display("FAIL df_c2 got dhit=%b ihit=%b iwait=%b want 1 0 1",
               bus.dhit, bus.ihit, bus.iwait);
    end
    @(negedge clk);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 ||
        bus.iwait !== 1'b1) begin
      bad++;
      $display("FAIL df_c3 got ren=%b wen=%b iwait=%b want 0 0 1",
               bus.ramREN, bus.ramWEN, bus.iwait);
    end
    @(negedge clk);
    bus.ramReady = 1'b1;
    bus.ramload = 32'h0BAD_F00D;
    #1;
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 ||
        bus.ihit !== 1'b1 || bus.iload !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL df_c4 got ren=%b a=%h ihit=%b load=%h",
               bus.ramREN, bus.ramaddr, bus.ihit, bus.iload);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    int errcyc;
    int hits;
    errcyc = 0;
    hits = 0;
    do_reset();
    drive(0, 0, 1, 0, 32'h200, 0, 0, 0);
    for (int n = 1; n <= TO + 20; n++) begin
      @(negedge clk);
      #1;
      if (bus.dhit) hits++;
      if (bus.err) begin
        errcyc = n;
        break;
      end
    end
    total++;
    if (errcyc != TO + 1) begin
      bad++;
      $display("FAIL timeout_cycle got=%0d want=%0d", errcyc, TO + 1);
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL timeout_hit got=%0d want=0", hits);
    end
    @(negedge clk);
    bus.dREN = 1'b0;
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle got ren=%b err=%b want 0 0",
               bus.ramREN, bus.err);
    end
  endtask

  task automatic test_drop();
    do_reset();
    drive(1, 32'h44, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.iREN = 1'b0;
    #1;
    total++;
    if (bus.ramREN !== 1'b1 || bus.iwait !== 1'b0) begin
      bad++;
      $display("FAIL drop_c1 got ren=%b iwait=%b want 1 0",
               bus.ramREN, bus.iwait);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
      bad++;
      $display("FAIL drop_c2 got ren=%b a=%h want 1 44",
               bus.ramREN, bus.ramaddr);
    end
    @(negedge clk);
    bus.ramReady = 1'b1;
    bus.ramload = 32'hCAFE;
    #1;
    total++;
    if (bus.ramREN !== 1'b1 || bus.ihit !== 1'b0 ||
        bus.iload !== 32'd0) begin
      bad++;
      $display("FAIL drop_c3 got ren=%b ihit=%b load=%h want 1 0 0",
               bus.ramREN, bus.ihit, bus.iload);
    end
    @(negedge clk);
    bus.ramReady = 1'b0;
    #1;
    total++;
    if (bus.ramREN !== 1'b0) begin
      bad++;
      $display("FAIL drop_c4 got ren=%b want 0", bus.ramREN);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 0, 1, 32'h300, 32'h77, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h300) begin
      bad++;
      $display("FAIL rstmid_c1 got wen=%b a=%h want 1 300",
               bus.ramWEN, bus.ramaddr);
    end
    @(negedge clk);
    bus.RST = 1'b1;
    @(negedge clk);
    bus.RST = 1'b0;
    bus.ramReady = 1'b1;
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 ||
        bus.dhit !== 1'b0 || bus.ramaddr !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_c3 got r=%b w=%b hit=%b a=%h want 0 0 0 0",
               bus.ramREN, bus.ramWEN, bus.dhit, bus.ramaddr);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_starve();
    bit seq[$];
    int n;
    do_reset();
    drive(1, 32'h8, 1, 0, 32'hC, 0, 1, 32'h99);
    n = 0;
    while (seq.size() < 10 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.ihit) seq.push_back(1'b1);
      else if (bus.dhit) seq.push_back(1'b0);
    end
    total++;
    if (seq.size() != 10) begin
      bad++;
      $display("FAIL starve_count got=%0d want=10", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      bit want;
`ifdef MEM_ARB_STARVE_GUARD_EN
      want = ((i % (SM + 1)) == SM);
`else
      want = 1'b0;
`endif
      total++;
      if (seq[i] !== want) begin
        bad++;
        $display("FAIL starve_grant%0d got_instr=%b want=%b",
                 i, seq[i], want);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.RST = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 2) != 0, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom, $urandom,
            $urandom_range(0, 4) < 2, $urandom);
      #1;
      model_eval();
      total++;
      if (flags() !== e_flags) begin
        bad++;
        $display("FAIL rnd_flags c=%0d got=%b want=%b",
                 c, flags(), e_flags);
      end
      total++;
      if (bus.ramaddr !== e_addr || bus.ramstore !== e_store) begin
        bad++;
        $display("FAIL rnd_cmd c=%0d got=%h/%h want=%h/%h",
                 c, bus.ramaddr, bus.ramstore, e_addr, e_store);
      end
      total++;
      if (bus.iload !== e_iload || bus.dload !== e_dload) begin
        bad++;
        $display("FAIL rnd_load c=%0d got=%h/%h want=%h/%h",
                 c, bus.iload, bus.dload, e_iload, e_dload);
      end
      model_adv();
      @(negedge clk);
    end
    bus.RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_ifetch();
    test_data_first();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_starve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
